gb_mem_arbiter: RTL

- Parametrised N-master, fixed-6-region memory arbiter/router for the GBC memory subsystem.
- Masters are CPU, PPU, the DMA read port, the DMA write port, and any future ones such as HDMA.
- Arbitrates master requests onto one registered slave bus and decodes the Game Boy address map into one-hot region selects.
- Handles echo-RAM aliasing, unusable-region accesses and per-master access restrictions.
- Reports same-port and boundary errors.

---
 rtl/gb_mem_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/gb_mem_arbiter.sv
// N-master arbiter and router for the GBC memory map: one registered slave bus,
// one-hot region selects, echo-RAM translation, region permission and same-port errors.
module gb_mem_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ARB_MODE = 0,
  parameter logic [6*NUM_MASTERS-1:0] ALLOWED_MASK = {NUM_MASTERS{6'b111111}},
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                       I_CLK,
  input  logic                       I_RESET,
  input  logic [16*NUM_MASTERS-1:0]  I_M_ADDR,
  input  logic [8*NUM_MASTERS-1:0]   I_M_WDATA,
  input  logic [NUM_MASTERS-1:0]     I_M_WE_L,
  input  logic [NUM_MASTERS-1:0]     I_M_RE_L,
  output logic [8*NUM_MASTERS-1:0]   O_M_RDATA,
  output logic [NUM_MASTERS-1:0]     O_M_ACK,
  output logic [15:0]                O_SLV_ADDR,
  output logic [7:0]                 O_SLV_WDATA,
  output logic                       O_SLV_WE_L,
  output logic                       O_SLV_RE_L,
  output logic [5:0]                 O_SLV_SEL,
  input  logic [47:0]                I_SLV_RDATA,
  output logic                       O_SAME_PORT_ERR,
  output logic                       O_BOUNDARY_ERR,
  output logic [MW-1:0]              O_ERR_MASTER
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

  state_t                     state_q, state_d;
  logic [MW-1:0]              rr_q, rr_d, gnt_q, gnt_d, err_m_q, err_m_d;
  logic                       is_rd_q, is_rd_d, bnd_q, bnd_d;
  logic [5:0]                 sel_q, sel_d;
  logic [15:0]                addr_q, addr_d;
  logic [7:0]                 wdata_q, wdata_d;
  logic                       we_l_q, we_l_d, re_l_q, re_l_d;
  logic [NUM_MASTERS-1:0]     ack_q, ack_d;
  logic [8*NUM_MASTERS-1:0]   rdata_q, rdata_d;
  logic                       sp_err_q, sp_err_d, bnd_err_q, bnd_err_d;

  logic [NUM_MASTERS-1:0]     pending, both_low;
  logic                       found;
  logic [MW-1:0]              gnt_idx;
  logic [15:0]                m_addr, x_addr;
  logic [5:0]                 region, allowed;
  logic [7:0]                 rd_mux;
  int                         idx;

  // Region decode; an all-zero result marks the unusable FEA0-FEFF hole.
  always_comb begin
    region = 6'b000000;
    x_addr = m_addr;
    if (m_addr < 16'h8000)      region = 6'b000001;
    else if (m_addr < 16'hA000) region = 6'b000010;
    else if (m_addr < 16'hC000) region = 6'b000001;
    else if (m_addr < 16'hE000) region = 6'b000100;
    else if (m_addr < 16'hFE00) begin
      region = 6'b000100;
      x_addr = m_addr - 16'h2000;
    end
    else if (m_addr < 16'hFEA0) region = 6'b001000;
    else if (m_addr < 16'hFF00) region = 6'b000000;
    else if (m_addr < 16'hFF80) region = 6'b010000;
    else if (m_addr == 16'hFFFF) region = 6'b010000;
    else                        region = 6'b100000;
  end

  always_comb begin
    pending  = I_M_WE_L ^ I_M_RE_L;
    both_low = ~I_M_WE_L & ~I_M_RE_L;
    found    = 1'b0;
    gnt_idx  = '0;
    idx      = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = (ARB_MODE == 1) ? ((int'(rr_q) + i) % NUM_MASTERS) : i;
      if (!found && pending[idx]) begin
        found   = 1'b1;
        gnt_idx = MW'(idx);
      end
    end
    m_addr  = I_M_ADDR[16*gnt_idx +: 16];
    allowed = ALLOWED_MASK[6*gnt_idx +: 6];
    rd_mux  = 8'h00;
    for (int r = 0; r < 6; r++)
      if (sel_q[r]) rd_mux = rd_mux | I_SLV_RDATA[8*r +: 8];
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    is_rd_d   = is_rd_q;
    bnd_d     = bnd_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_l_d    = we_l_q;
    re_l_d    = re_l_q;
    ack_d     = '0;
    rdata_d   = rdata_q;
    sp_err_d  = |both_low;
    bnd_err_d = 1'b0;
    err_m_d   = err_m_q;
    for (int m = NUM_MASTERS - 1; m >= 0; m--)
      if (both_low[m]) err_m_d = MW'(m);
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_ACCESS;
          gnt_d   = gnt_idx;
          is_rd_d = ~I_M_RE_L[gnt_idx];
          sel_d   = region & allowed;
          bnd_d   = |(region & ~allowed);
          addr_d  = x_addr;
          wdata_d = I_M_WDATA[8*gnt_idx +: 8];
          we_l_d  = ~((I_M_RE_L[gnt_idx]) & (|(region & allowed)));
          re_l_d  = ~((~I_M_RE_L[gnt_idx]) & (|(region & allowed)));
          if (ARB_MODE == 1) rr_d = MW'((int'(gnt_idx) + 1) % NUM_MASTERS);
        end
      end
      ST_ACCESS: begin
        state_d        = ST_RESP;
        ack_d[gnt_q]   = 1'b1;
        if (is_rd_q)
          rdata_d[8*gnt_q +: 8] = (|sel_q) ? rd_mux : 8'hFF;
        sel_d  = 6'b000000;
        we_l_d = 1'b1;
        re_l_d = 1'b1;
        if (bnd_q) begin
          bnd_err_d = 1'b1;
          err_m_d   = gnt_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q   <= ST_IDLE;
      rr_q      <= '0;
      gnt_q     <= '0;
      is_rd_q   <= 1'b0;
      bnd_q     <= 1'b0;
      sel_q     <= 6'b000000;
      addr_q    <= 16'h0000;
      wdata_q   <= 8'h00;
      we_l_q    <= 1'b1;
      re_l_q    <= 1'b1;
      ack_q     <= '0;
      rdata_q   <= {NUM_MASTERS{8'hFF}};
      sp_err_q  <= 1'b0;
      bnd_err_q <= 1'b0;
      err_m_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      is_rd_q   <= is_rd_d;
      bnd_q     <= bnd_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_l_q    <= we_l_d;
      re_l_q    <= re_l_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      sp_err_q  <= sp_err_d;
      bnd_err_q <= bnd_err_d;
      err_m_q   <= err_m_d;
    end
  end

  assign O_M_RDATA       = rdata_q;
  assign O_M_ACK         = ack_q;
  assign O_SLV_ADDR      = addr_q;
  assign O_SLV_WDATA     = wdata_q;
  assign O_SLV_WE_L      = we_l_q;
  assign O_SLV_RE_L      = re_l_q;
  assign O_SLV_SEL       = sel_q;
  assign O_SAME_PORT_ERR = sp_err_q;
  assign O_BOUNDARY_ERR  = bnd_err_q;
  assign O_ERR_MASTER    = err_m_q;

endmodule
